// File: rtl/keystream_gen.sv
// keystream_gen: 16-bit Galois LFSR keystream bytes over valid/ready; ports clk, rst_n, ena, seed_byte/seed_valid (lo then hi), ks_byte/ks_valid/ks_ready, byte_count
module keystream_gen #(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] seed_byte,
  input  logic       seed_valid,
  output logic [7:0] ks_byte,
  output logic       ks_valid,
  input  logic       ks_ready,
  output logic [7:0] byte_count
);
  typedef enum logic [1:0] {FILL, READY, SEED_HI} state_t;
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n, lfsr_step, seed;
  logic [2:0] cnt, cnt_n;
  logic [7:0] ks_n, bc_n, seed_lo, seed_lo_n;
  logic b;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= FILL;
      lfsr <= DEFAULT_SEED;
      cnt <= '0;
      ks_byte <= '0;
      byte_count <= '0;
      seed_lo <= '0;
    end else if (ena) begin
      state <= state_n;
      lfsr <= lfsr_n;
      cnt <= cnt_n;
      ks_byte <= ks_n;
      byte_count <= bc_n;
      seed_lo <= seed_lo_n;
    end
  always_comb begin
    b = lfsr[0];
    lfsr_step = (lfsr >> 1) ^ (b ? TAPS : '0);
    seed = {seed_byte, seed_lo};
    state_n = state;
    lfsr_n = lfsr;
    cnt_n = cnt;
    ks_n = ks_byte;
    bc_n = byte_count;
    seed_lo_n = seed_lo;
    if (state == SEED_HI) begin
      if (seed_valid) begin
        state_n = FILL;
        lfsr_n = (seed == '0) ? DEFAULT_SEED : seed;
        cnt_n = '0;
        bc_n = '0;
      end
    end else if (seed_valid) begin
      seed_lo_n = seed_byte;
      state_n = SEED_HI;
    end else if (state == FILL) begin
      lfsr_n = lfsr_step;
      ks_n = {ks_byte[6:0], b};
      cnt_n = cnt + 3'd1;
      state_n = (cnt == 3'd7) ? READY : FILL;
    end else if (ks_ready) begin
      bc_n = byte_count + 8'd1;
      cnt_n = '0;
      state_n = FILL;
    end
  end
  always_comb ks_valid = (state == READY);
endmodule

// File: doc/keystream_gen.md
Name: keystream_gen

Overview:
Upstream keystream source for stream_cypher. Produces one 8-bit keystream byte at a time from a seedable 16-bit Galois LFSR. The byte is offered to the cipher stage over a valid/ready handshake; the cipher's inc pulse drives ks_ready. Seeds are loaded as two bytes over an 8-bit bus so the block fits the same 8-bit I/O budget.

Parameters:
LFSR_W, 16, LFSR width in bits (fixed at 16 for this design).
TAPS, 16'hB400, Galois feedback mask XORed into the state when the shifted-out bit is 1.
DEFAULT_SEED, 16'hACE1, state loaded at reset and substituted for any all-zero seed.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
ena  in  1  clock enable; when 0, all state (including reset-free registers) holds
seed_byte  in  8  seed data, low byte first then high byte
seed_valid  in  1  seed_byte valid this cycle
ks_byte  out  8  current keystream byte
ks_valid  out  1  ks_byte holds a complete, unconsumed byte
ks_ready  in  1  consumer accepts ks_byte this cycle
byte_count  out  8  bytes consumed since reset or last seed load

Behaviour:
- Synchronous reset (rst_n=0 at an edge, regardless of ena): lfsr=DEFAULT_SEED; state=FILL; bit counter=0; ks_byte=0x00; ks_valid=0; byte_count=0x00.
- ena=0 with rst_n=1: no register changes and handshakes are ignored. The outputs hold their values.
- LFSR step: b=lfsr[0]; lfsr=(lfsr>>1) ^ (b ? TAPS : 0); ks_byte={ks_byte[6:0], b}. The first bit generated ends up as the MSB.
- States:
  - FILL: one step per enabled edge; counter increments. On the 8th step, go to READY and set ks_valid=1 at that same edge. While in FILL, ks_valid=0 and ks_byte shows partial shift contents (don't-care).
  - READY: ks_byte is stable. When ks_valid and ks_ready are both 1 at an edge, the byte is consumed: byte_count+=1 (wraps 0xFF->0x00), ks_valid=0, counter=0, state=FILL.
  - SEED_HI: waiting for the high seed byte; ks_valid=0.
- Latency: 8 enabled edges after entering FILL. From the consume edge H, the next byte is valid after edge H+8 (steps on H+1..H+8). From reset edge R, the first byte is valid after R+8.
- Seed load:
  - seed_valid=1 in FILL or READY: latch seed_byte as the low byte and go to SEED_HI. ks_valid drops at that edge. Any pending byte is discarded and any simultaneous ks_ready is ignored (seed has priority, byte_count does not increment).
  - seed_valid=1 in SEED_HI: lfsr={seed_byte, low}, or DEFAULT_SEED if that value is 0x0000. Then byte_count=0, counter=0, state=FILL.
  - seed_valid=0 in SEED_HI: wait indefinitely. ks_ready is ignored.
- ks_ready is ignored when ks_valid=0.
- LFSR state is never 0x0000 (zero-seed substitution guarantees this).

Test Plan:
- Reset, ena=1, ks_ready=0 -> ks_valid=0 for edges R+1..R+7; ks_valid=1 and ks_byte=0x87 after R+8; holds 0x87 for 20 further cycles.
- Consume first byte (ks_ready pulse one cycle) -> byte_count=0x01, ks_valid low for exactly 8 cycles, then rises with the next byte from lfsr=0xC2C4. Compare against a reference model for 300 consumed bytes; byte_count wraps 0xFF->0x00.
- Seed 0x00 then 0x00 mid-FILL -> byte_count=0x00, first byte after load is 0x87 (zero-seed substitution).
- Seed 0xE1, idle 5 cycles, 0xAC while in READY with ks_ready=1 on the first seed edge -> no consume, byte_count=0, ks_valid=0 during SEED_HI, next byte 0x87.
- Drop ena for 4 cycles during FILL and during READY with ks_ready=1 -> no steps, no consume; latency extends by exactly 4 cycles and the byte sequence is unchanged.
- Assert rst_n=0 mid-FILL with ena=0 -> reset takes effect; first byte 0x87 after 8 enabled edges.
